// File: rtl/csr_access_ctrl.sv
// CSR access sequencer: runs Zicsr read/modify/write, ecall and mret against the CSR file.
// Optional mstatus MIE/MPIE/MPP update on ecall/mret is enabled by defining CSR_MSTATUS_UPDATE_EN.
module csr_access_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] ECALL_CAUSE = 32'hb
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_funct3,
    input  logic                  in_is_ecall,
    input  logic                  in_is_mret,
    input  logic [ADDR_WIDTH-1:0] in_csr_addr,
    input  logic [DATA_WIDTH-1:0] in_rs1_val,
    input  logic [4:0]            in_rs1_idx,
    input  logic [DATA_WIDTH-1:0] in_pc,
    output logic [ADDR_WIDTH-1:0] csr_addr,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  csr_wen,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_rd_data,
    output logic                  out_redirect,
    output logic [DATA_WIDTH-1:0] out_redirect_pc,
    output logic                  out_illegal
);

    localparam logic [ADDR_WIDTH-1:0] MSTATUS = ADDR_WIDTH'(12'h300);
    localparam logic [ADDR_WIDTH-1:0] MTVEC   = ADDR_WIDTH'(12'h305);
    localparam logic [ADDR_WIDTH-1:0] MEPC    = ADDR_WIDTH'(12'h341);
    localparam logic [ADDR_WIDTH-1:0] MCAUSE  = ADDR_WIDTH'(12'h342);

    // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE and the response is held unchanged until out_ready.
    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WRITE, S_EPC, S_CAUSE, S_RESP, S_READ2, S_MSTAT
    } state_t;

    typedef enum logic [1:0] {K_CSR, K_ECALL, K_MRET, K_ILL} kind_t;

    state_t                state_q, state_d;
    kind_t                 kind_q, kind_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] rs1_val_q, rs1_val_d;
    logic [4:0]            rs1_idx_q, rs1_idx_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] old_q, old_d;
`ifdef CSR_MSTATUS_UPDATE_EN
    logic [DATA_WIDTH-1:0] mstat_q, mstat_d;
    logic [DATA_WIDTH-1:0] mstat_new;
`endif

    logic [DATA_WIDTH-1:0] src;
    logic [DATA_WIDTH-1:0] new_val;
    logic                  write_cond;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            kind_q    <= K_CSR;
            funct3_q  <= '0;
            addr_q    <= '0;
            rs1_val_q <= '0;
            rs1_idx_q <= '0;
            pc_q      <= '0;
            old_q     <= '0;
`ifdef CSR_MSTATUS_UPDATE_EN
            mstat_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            funct3_q  <= funct3_d;
            addr_q    <= addr_d;
            rs1_val_q <= rs1_val_d;
            rs1_idx_q <= rs1_idx_d;
            pc_q      <= pc_d;
            old_q     <= old_d;
`ifdef CSR_MSTATUS_UPDATE_EN
            mstat_q   <= mstat_d;
`endif
        end
    end

    // funct3[2] selects the zero-extended 5-bit immediate instead of rs1.
    always_comb begin
        src        = funct3_q[2] ? {{(DATA_WIDTH-5){1'b0}}, rs1_idx_q} : rs1_val_q;
        write_cond = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);
        case (funct3_q[1:0])
            2'b01:   new_val = src;
            2'b10:   new_val = old_q | src;
            default: new_val = old_q & ~src;
        endcase
    end

`ifdef CSR_MSTATUS_UPDATE_EN
    always_comb begin
        mstat_new = mstat_q;
        if (kind_q == K_ECALL) begin
            mstat_new[7]     = mstat_q[3];
            mstat_new[3]     = 1'b0;
            mstat_new[12:11] = 2'b11;
        end else begin
            mstat_new[3]     = mstat_q[7];
            mstat_new[7]     = 1'b1;
            mstat_new[12:11] = 2'b00;
        end
    end
`endif

    always_comb begin
        state_d         = state_q;
        kind_d          = kind_q;
        funct3_d        = funct3_q;
        addr_d          = addr_q;
        rs1_val_d       = rs1_val_q;
        rs1_idx_d       = rs1_idx_q;
        pc_d            = pc_q;
        old_d           = old_q;
`ifdef CSR_MSTATUS_UPDATE_EN
        mstat_d         = mstat_q;
`endif
        in_ready        = 1'b0;
        out_valid       = 1'b0;
        csr_addr        = '0;
        csr_wen         = 1'b0;
        csr_wdata       = '0;
        out_rd_data     = '0;
        out_redirect    = 1'b0;
        out_redirect_pc = '0;
        out_illegal     = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    funct3_d  = in_funct3;
                    addr_d    = in_csr_addr;
                    rs1_val_d = in_rs1_val;
                    rs1_idx_d = in_rs1_idx;
                    pc_d      = in_pc;
                    old_d     = '0;
                    if (in_is_ecall) begin
                        kind_d  = K_ECALL;
                        state_d = S_READ;
                    end else if (in_is_mret) begin
                        kind_d  = K_MRET;
                        state_d = S_READ;
                    end else if (in_funct3[1:0] == 2'b00) begin
                        kind_d  = K_ILL;
                        state_d = S_RESP;
                    end else begin
                        kind_d  = K_CSR;
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                case (kind_q)
                    K_ECALL: csr_addr = MTVEC;
                    K_MRET:  csr_addr = MEPC;
                    default: csr_addr = addr_q;
                endcase
                old_d = csr_rdata;
                if (kind_q == K_ECALL) begin
                    state_d = S_EPC;
                end else if (kind_q == K_MRET) begin
`ifdef CSR_MSTATUS_UPDATE_EN
                    state_d = S_READ2;
`else
                    state_d = S_RESP;
`endif
                end else begin
                    state_d = write_cond ? S_WRITE : S_RESP;
                end
            end
            S_WRITE: begin
                csr_addr  = addr_q;
                csr_wen   = 1'b1;
                csr_wdata = new_val;
                state_d   = S_RESP;
            end
            S_EPC: begin
                csr_addr  = MEPC;
                csr_wen   = 1'b1;
                csr_wdata = pc_q;
                state_d   = S_CAUSE;
            end
            S_CAUSE: begin
                csr_addr  = MCAUSE;
                csr_wen   = 1'b1;
                csr_wdata = ECALL_CAUSE;
`ifdef CSR_MSTATUS_UPDATE_EN
                state_d   = S_READ2;
`else
                state_d   = S_RESP;
`endif
            end
`ifdef CSR_MSTATUS_UPDATE_EN
            S_READ2: begin
                csr_addr = MSTATUS;
                mstat_d  = csr_rdata;
                state_d  = S_MSTAT;
            end
            S_MSTAT: begin
                csr_addr  = MSTATUS;
                csr_wen   = 1'b1;
                csr_wdata = mstat_new;
                state_d   = S_RESP;
            end
`endif
            S_RESP: begin
                out_valid = 1'b1;
                // For ecall/mret old_q holds the captured mtvec/mepc.
                if (kind_q == K_CSR) out_rd_data = old_q;
                if (kind_q == K_ECALL || kind_q == K_MRET) begin
                    out_redirect    = 1'b1;
                    out_redirect_pc = old_q;
                end
                out_illegal = (kind_q == K_ILL);
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl: vector table plus scoreboard of expected CSR writes and responses.
module tb_csr_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic        in_is_ecall;
  logic        in_is_mret;
  logic [11:0] in_csr_addr;
  logic [31:0] in_rs1_val;
  logic [4:0]  in_rs1_idx;
  logic [31:0] in_pc;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic        csr_wen;
  logic [31:0] csr_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rd_data;
  logic        out_redirect;
  logic [31:0] out_redirect_pc;
  logic        out_illegal;

  csr_access_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_is_ecall(in_is_ecall), .in_is_mret(in_is_mret), .in_csr_addr(in_csr_addr),
    .in_rs1_val(in_rs1_val), .in_rs1_idx(in_rs1_idx), .in_pc(in_pc),
    .csr_addr(csr_addr), .csr_rdata(csr_rdata), .csr_wen(csr_wen), .csr_wdata(csr_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd_data(out_rd_data),
    .out_redirect(out_redirect), .out_redirect_pc(out_redirect_pc), .out_illegal(out_illegal)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  f3;
    logic        ec;
    logic        mr;
    logic [11:0] addr;
    logic [31:0] rs1;
    logic [4:0]  idx;
    logic [31:0] pc;
    logic [31:0] rdata;
    int          nw;
    logic [11:0] w0a;
    logic [31:0] w0d;
    logic [11:0] w1a;
    logic [31:0] w1d;
    logic [31:0] rd;
    logic        redir;
    logic [31:0] rpc;
    logic        ill;
    int          lat;
  } vec_t;

  // scoreboard
  logic [43:0] exp_w_q[$];
  logic [65:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [65:0] act, input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (csr_wen) begin
        if (exp_w_q.size() == 0) check("unexpected_csr_wen", {22'd0, csr_addr, csr_wdata}, 66'd0);
        else check("csr_write", {22'd0, csr_addr, csr_wdata}, {22'd0, exp_w_q.pop_front()});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_resp", 66'd1, 66'd0);
        else check("response", {out_illegal, out_redirect, out_redirect_pc, out_rd_data}, exp_q.pop_front());
      end
    end
  end

  function automatic vec_t mk(input logic [2:0] f3, input logic ec, input logic mr,
                              input logic [11:0] addr, input logic [31:0] rs1, input logic [4:0] idx,
                              input logic [31:0] pc, input logic [31:0] rdata, input int nw,
                              input logic [11:0] w0a, input logic [31:0] w0d,
                              input logic [11:0] w1a, input logic [31:0] w1d,
                              input logic [31:0] rd, input logic redir, input logic [31:0] rpc,
                              input logic ill, input int lat);
    vec_t v;
    v.f3 = f3; v.ec = ec; v.mr = mr; v.addr = addr; v.rs1 = rs1; v.idx = idx;
    v.pc = pc; v.rdata = rdata; v.nw = nw; v.w0a = w0a; v.w0d = w0d; v.w1a = w1a; v.w1d = w1d;
    v.rd = rd; v.redir = redir; v.rpc = rpc; v.ill = ill; v.lat = lat;
    return v;
  endfunction

  // driver: one instruction, optional response back-pressure
  task automatic run_txn(input vec_t v, input string nm, input int stall);
    int lat;
    if (v.nw > 0) exp_w_q.push_back({v.w0a, v.w0d});
    if (v.nw > 1) exp_w_q.push_back({v.w1a, v.w1d});
    exp_q.push_back({v.ill, v.redir, v.rpc, v.rd});
    @(posedge clk); #1;
    check({nm, "_in_ready_idle"}, {65'd0, in_ready}, 66'd1);
    in_funct3 = v.f3; in_is_ecall = v.ec; in_is_mret = v.mr; in_csr_addr = v.addr;
    in_rs1_val = v.rs1; in_rs1_idx = v.idx; in_pc = v.pc; csr_rdata = v.rdata;
    out_ready = (stall == 0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check({nm, "_latency"}, 66'(lat), 66'(v.lat));
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        check({nm, "_stall_valid"}, {65'd0, out_valid}, 66'd1);
        check({nm, "_stall_pc"}, {34'd0, out_redirect_pc}, {34'd0, v.rpc});
        check({nm, "_stall_wen"}, {65'd0, csr_wen}, 66'd0);
        if (i < stall - 1) @(negedge clk);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({nm, "_in_ready_after"}, {65'd0, in_ready}, 66'd1);
    check({nm, "_valid_after"}, {65'd0, out_valid}, 66'd0);
  endtask

  vec_t vecs[15];

  initial begin
    vec_t v;
    logic [31:0] src;
    logic [31:0] nv;
    logic        wr;
    logic [2:0]  f3_tab[6];

    vecs[0]  = mk(3'd1, 0, 0, 12'h305, 32'h80000100, 5'd5, 0, 32'h0,      1, 12'h305, 32'h80000100, 0, 0, 32'h0, 0, 0, 0, 3);
    vecs[1]  = mk(3'd2, 0, 0, 12'h300, 32'hffffffff, 5'd0, 0, 32'h1800,   0, 0, 0, 0, 0, 32'h1800, 0, 0, 0, 2);
    vecs[2]  = mk(3'd7, 0, 0, 12'h300, 32'h0,        5'd8, 0, 32'h1808,   1, 12'h300, 32'h1800, 0, 0, 32'h1808, 0, 0, 0, 3);
    vecs[3]  = mk(3'd0, 1, 0, 12'h0,   32'h0,        5'd0, 32'h80000040, 32'h80000200,
                  2, 12'h341, 32'h80000040, 12'h342, 32'hb, 32'h0, 1, 32'h80000200, 0, 4);
    vecs[4]  = mk(3'd2, 0, 0, 12'h340, 32'hf0,       5'd3, 0, 32'hf,      1, 12'h340, 32'hff, 0, 0, 32'hf, 0, 0, 0, 3);
    vecs[5]  = mk(3'd3, 0, 0, 12'h344, 32'hff00ff00, 5'd7, 0, 32'hffffffff, 1, 12'h344, 32'h00ff00ff, 0, 0, 32'hffffffff, 0, 0, 0, 3);
    vecs[6]  = mk(3'd5, 0, 0, 12'h341, 32'hffffffff, 5'd0, 0, 32'h1234,   1, 12'h341, 32'h0, 0, 0, 32'h1234, 0, 0, 0, 3);
    vecs[7]  = mk(3'd6, 0, 0, 12'h304, 32'h0,        5'h1f, 0, 32'h100,   1, 12'h304, 32'h11f, 0, 0, 32'h100, 0, 0, 0, 3);
    vecs[8]  = mk(3'd7, 0, 0, 12'h300, 32'hffffffff, 5'd0, 0, 32'habcd,   0, 0, 0, 0, 0, 32'habcd, 0, 0, 0, 2);
    vecs[9]  = mk(3'd0, 0, 0, 12'h300, 32'h1,        5'd1, 0, 32'h55,     0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 1);
    vecs[10] = mk(3'd4, 0, 0, 12'h300, 32'h1,        5'd1, 0, 32'h55,     0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 1);
    vecs[11] = mk(3'd0, 1, 1, 12'h0,   32'h0,        5'd0, 32'h80000080, 32'h80000300,
                  2, 12'h341, 32'h80000080, 12'h342, 32'hb, 32'h0, 1, 32'h80000300, 0, 4);
    vecs[12] = mk(3'd0, 0, 1, 12'h0,   32'h0,        5'd0, 0, 32'h80000044, 0, 0, 0, 0, 0, 32'h0, 1, 32'h80000044, 0, 2);
    vecs[13] = mk(3'd1, 1, 0, 12'h305, 32'h1234,     5'd3, 32'h80000010, 32'h80000400,
                  2, 12'h341, 32'h80000010, 12'h342, 32'hb, 32'h0, 1, 32'h80000400, 0, 4);
    vecs[14] = mk(3'd3, 0, 0, 12'h300, 32'hffffffff, 5'd0, 0, 32'h7,      0, 0, 0, 0, 0, 32'h7, 0, 0, 0, 2);

    rst = 1'b1; in_valid = 1'b0; in_funct3 = 3'd0; in_is_ecall = 1'b0; in_is_mret = 1'b0;
    in_csr_addr = '0; in_rs1_val = '0; in_rs1_idx = '0; in_pc = '0; csr_rdata = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {65'd0, in_ready}, 66'd1);
    check("rst_out_valid", {65'd0, out_valid}, 66'd0);
    check("rst_csr_wen", {65'd0, csr_wen}, 66'd0);
    check("rst_outputs", {out_illegal, out_redirect, out_redirect_pc, out_rd_data}, 66'd0);
    check("rst_csr_bus", {22'd0, csr_addr, csr_wdata}, 66'd0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run_txn(vecs[i], $sformatf("vec%0d", i), 0);

    // mret held off by WBU for four cycles
    run_txn(vecs[12], "mret_stall", 4);

    // reset during the write cycle of a CSRRW
    @(posedge clk); #1;
    in_funct3 = 3'd1; in_is_ecall = 1'b0; in_is_mret = 1'b0; in_csr_addr = 12'h305;
    in_rs1_val = 32'hdeadbeef; in_rs1_idx = 5'd1; csr_rdata = 32'h0; out_ready = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("midrst_wen_before", {65'd0, csr_wen}, 66'd1);
    rst = 1'b1;
    #1;
    check("midrst_wen", {65'd0, csr_wen}, 66'd0);
    check("midrst_out_valid", {65'd0, out_valid}, 66'd0);
    check("midrst_in_ready", {65'd0, in_ready}, 66'd1);
    check("midrst_csr_bus", {22'd0, csr_addr, csr_wdata}, 66'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_txn(vecs[0], "post_rst_csrrw", 0);

    // random Zicsr traffic against a small reference model
    f3_tab[0] = 3'd1; f3_tab[1] = 3'd2; f3_tab[2] = 3'd3;
    f3_tab[3] = 3'd5; f3_tab[4] = 3'd6; f3_tab[5] = 3'd7;
    for (int i = 0; i < 12; i++) begin
      v = mk(f3_tab[$urandom_range(0, 5)], 0, 0, 12'($urandom_range(0, 4095)), $urandom,
             5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31)), 0, $urandom,
             0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      src = v.f3[2] ? {27'd0, v.idx} : v.rs1;
      wr  = (v.f3[1:0] == 2'b01) || (v.idx != 5'd0);
      if (v.f3[1:0] == 2'b01)      nv = src;
      else if (v.f3[1:0] == 2'b10) nv = v.rdata | src;
      else                         nv = v.rdata & ~src;
      v.nw  = wr ? 1 : 0;
      v.w0a = v.addr;
      v.w0d = nv;
      v.rd  = v.rdata;
      v.lat = wr ? 3 : 2;
      run_txn(v, $sformatf("rand%0d", i), 0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("write_queue_drained", 66'(exp_w_q.size()), 66'd0);
    check("resp_queue_drained", 66'(exp_q.size()), 66'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
